// File: rtl/l2_lookup_arbiter.sv
// rtl/l2_lookup_arbiter.sv - L2 tag/state/line read-path scheduler for rsp, fwd, req and flush walker
module l2_lookup_arbiter #(
   parameter int SET_BITS     = 9,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rsp_valid,
   output logic                rsp_ready,
   input  logic [SET_BITS-1:0] rsp_set,
   input  logic                fwd_valid,
   output logic                fwd_ready,
   input  logic [SET_BITS-1:0] fwd_set,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [SET_BITS-1:0] req_set,
   input  logic                req_stall,
   input  logic                flush_valid,
   output logic                flush_ready,
   input  logic                done,
   output logic                rd_mem_en,
   output logic [SET_BITS-1:0] rd_set,
   output logic [1:0]          sel,
   output logic                lookup_valid,
   output logic                flush_active,
   output logic                flush_done
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

   localparam logic [1:0] SEL_RSP   = 2'd0;
   localparam logic [1:0] SEL_FWD   = 2'd1;
   localparam logic [1:0] SEL_REQ   = 2'd2;
   localparam logic [1:0] SEL_FLUSH = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_READ   = 2'd1,
      ST_LOOKUP = 2'd2
   } state_t;

   state_t              state;
   state_t              next_state;
   logic [SET_BITS-1:0] set_q;
   logic [SET_BITS-1:0] flush_ptr;
   logic [1:0]          sel_q;
   logic                flush_active_q;
   logic [CNT_W-1:0]    starve_cnt;
   logic                rd_mem_en_q;
   logic                lookup_valid_q;
   logic                flush_done_q;

   logic                req_elig;
   logic                starved;
   logic                grant_rsp;
   logic                grant_fwd;
   logic                grant_req;
   logic                grant_fstart;
   logic                grant_fstep;
   logic                start;
   logic [SET_BITS-1:0] win_set;
   logic [1:0]          win_sel;

   // req is held off while the MSHRs are full and for the whole flush walk
   assign req_elig = req_valid & ~req_stall & ~flush_active_q;
   assign starved  = (starve_cnt == STARVE_MAX);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state: a grant or flush step launches the one-cycle read, done closes the lookup
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:   if (start) next_state = ST_READ;
         ST_READ:   next_state = ST_LOOKUP;
         ST_LOOKUP: if (done) next_state = ST_IDLE;
         default:   next_state = ST_IDLE;
      endcase
   end

   // Output/arbitration: pick at most one winner in IDLE; held off entirely during reset
   always_comb begin
      grant_rsp    = 1'b0;
      grant_fwd    = 1'b0;
      grant_req    = 1'b0;
      grant_fstart = 1'b0;
      grant_fstep  = 1'b0;
      win_set      = '0;
      win_sel      = SEL_RSP;
      if (state == ST_IDLE && !rst) begin
         if (rsp_valid) begin
            grant_rsp = 1'b1;
            win_set   = rsp_set;
            win_sel   = SEL_RSP;
         end else if (req_elig && starved) begin
            grant_req = 1'b1;
            win_set   = req_set;
            win_sel   = SEL_REQ;
         end else if (fwd_valid) begin
            grant_fwd = 1'b1;
            win_set   = fwd_set;
            win_sel   = SEL_FWD;
         end else if (req_elig) begin
            grant_req = 1'b1;
            win_set   = req_set;
            win_sel   = SEL_REQ;
         end else if (flush_active_q) begin
            grant_fstep = 1'b1;
            win_set     = flush_ptr;
            win_sel     = SEL_FLUSH;
         end else if (flush_valid) begin
            grant_fstart = 1'b1;
         end
      end
   end

   // The flush start only arms the walker; it does not occupy the buffers
   assign start = grant_rsp | grant_fwd | grant_req | grant_fstep;

   assign rsp_ready    = grant_rsp;
   assign fwd_ready    = grant_fwd;
   assign req_ready    = grant_req;
   assign flush_ready  = grant_fstart;
   assign rd_mem_en    = rd_mem_en_q;
   assign rd_set       = set_q;
   assign sel          = sel_q;
   assign lookup_valid = lookup_valid_q;
   assign flush_active = flush_active_q;
   assign flush_done   = flush_done_q;

   // Transaction owner, registered strobes, starvation counter and flush walker
   always_ff @(posedge clk) begin
      if (rst) begin
         set_q          <= '0;
         sel_q          <= SEL_RSP;
         flush_ptr      <= '0;
         flush_active_q <= 1'b0;
         starve_cnt     <= '0;
         rd_mem_en_q    <= 1'b0;
         lookup_valid_q <= 1'b0;
         flush_done_q   <= 1'b0;
      end else begin
         rd_mem_en_q    <= start;
         lookup_valid_q <= (state == ST_READ) || (state == ST_LOOKUP && !done);
         flush_done_q   <= 1'b0;
         if (start) begin
            set_q <= win_set;
            sel_q <= win_sel;
         end
         if (grant_fwd && req_elig && !starved) begin
            starve_cnt <= starve_cnt + 1'b1;
         end
         if (grant_req) begin
            starve_cnt <= '0;
         end
         if (grant_fstart) begin
            flush_active_q <= 1'b1;
            flush_ptr      <= '0;
         end
         if (state == ST_LOOKUP && done && sel_q == SEL_FLUSH) begin
            flush_ptr <= flush_ptr + 1'b1;
            if (&flush_ptr) begin
               flush_active_q <= 1'b0;
               flush_done_q   <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_l2_lookup_arbiter.sv
// tb/tb_l2_lookup_arbiter.sv - directed self-checking bench for l2_lookup_arbiter
module tb_l2_lookup_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       rsp_valid, fwd_valid, req_valid, req_stall, flush_valid, done;
   logic [8:0] rsp_set, fwd_set, req_set;

   logic       rsp_ready, fwd_ready, req_ready, flush_ready;
   logic       rd_mem_en, lookup_valid, flush_active, flush_done;
   logic [8:0] rd_set;
   logic [1:0] sel;

   logic       f_rsp_ready, f_fwd_ready, f_req_ready, f_flush_ready;
   logic       f_rd_mem_en, f_lookup_valid, f_flush_active, f_flush_done;
   logic [2:0] f_rd_set;
   logic [1:0] f_sel;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   l2_lookup_arbiter #(.SET_BITS(9), .STARVE_LIMIT(8)) u_dut (
      .clk(clk), .rst(rst),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_set(rsp_set),
      .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_set(fwd_set),
      .req_valid(req_valid), .req_ready(req_ready), .req_set(req_set),
      .req_stall(req_stall),
      .flush_valid(flush_valid), .flush_ready(flush_ready),
      .done(done),
      .rd_mem_en(rd_mem_en), .rd_set(rd_set), .sel(sel),
      .lookup_valid(lookup_valid), .flush_active(flush_active), .flush_done(flush_done)
   );

   l2_lookup_arbiter #(.SET_BITS(3), .STARVE_LIMIT(8)) u_flush (
      .clk(clk), .rst(rst),
      .rsp_valid(rsp_valid), .rsp_ready(f_rsp_ready), .rsp_set(rsp_set[2:0]),
      .fwd_valid(fwd_valid), .fwd_ready(f_fwd_ready), .fwd_set(fwd_set[2:0]),
      .req_valid(req_valid), .req_ready(f_req_ready), .req_set(req_set[2:0]),
      .req_stall(req_stall),
      .flush_valid(flush_valid), .flush_ready(f_flush_ready),
      .done(done),
      .rd_mem_en(f_rd_mem_en), .rd_set(f_rd_set), .sel(f_sel),
      .lookup_valid(f_lookup_valid), .flush_active(f_flush_active), .flush_done(f_flush_done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      rsp_valid = 1'b0; fwd_valid = 1'b0; req_valid = 1'b0;
      req_stall = 1'b0; flush_valid = 1'b0; done = 1'b0;
      rsp_set = '0; fwd_set = '0; req_set = '0;
      tick();
      tick();

      // reset state
      chk("rst_rsp_ready", rsp_ready, 0);
      chk("rst_fwd_ready", fwd_ready, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_flush_ready", flush_ready, 0);
      chk("rst_rd_mem_en", rd_mem_en, 0);
      chk("rst_rd_set", rd_set, 0);
      chk("rst_sel", sel, 0);
      chk("rst_lookup_valid", lookup_valid, 0);
      chk("rst_flush_active", flush_active, 0);
      chk("rst_flush_done", flush_done, 0);
      chk("rst_starve_cnt", u_dut.starve_cnt, 0);
      rst = 1'b0;
      tick();

      // single req, set 0x1A5, done on first LOOKUP cycle
      req_valid = 1'b1; req_set = 9'h1A5; #1;
      chk("t1_req_ready_T", req_ready, 1);
      chk("t1_rsp_ready_T", rsp_ready, 0);
      chk("t1_rd_mem_en_T", rd_mem_en, 0);
      tick();
      req_valid = 1'b0;
      chk("t1_rd_mem_en_T1", rd_mem_en, 1);
      chk("t1_rd_set_T1", rd_set, 9'h1A5);
      chk("t1_sel_T1", sel, 2);
      chk("t1_lookup_valid_T1", lookup_valid, 0);
      tick();
      chk("t1_rd_mem_en_T2", rd_mem_en, 0);
      chk("t1_lookup_valid_T2", lookup_valid, 1);
      done = 1'b1;
      tick();
      done = 1'b0;
      chk("t1_lookup_valid_T3", lookup_valid, 0);
      chk("t1_rd_mem_en_T3", rd_mem_en, 0);
      req_valid = 1'b1; req_set = 9'h0F0; #1;
      chk("t1_regrant_T3", req_ready, 1);
      tick();
      req_valid = 1'b0;
      chk("t1_regrant_rd_set", rd_set, 9'h0F0);
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;

      // rsp, fwd, req all valid together: order rsp, fwd, req
      rsp_valid = 1'b1; rsp_set = 9'h011;
      fwd_valid = 1'b1; fwd_set = 9'h022;
      req_valid = 1'b1; req_set = 9'h033; #1;
      chk("t2_rsp_ready", rsp_ready, 1);
      chk("t2_fwd_ready_a", fwd_ready, 0);
      chk("t2_req_ready_a", req_ready, 0);
      tick();
      rsp_valid = 1'b0;
      chk("t2_sel_rsp", sel, 0);
      chk("t2_rd_set_rsp", rd_set, 9'h011);
      chk("t2_fwd_ready_read", fwd_ready, 0);
      tick();
      done = 1'b1;
      tick();
      done = 1'b0; #1;
      chk("t2_fwd_ready", fwd_ready, 1);
      chk("t2_req_ready_b", req_ready, 0);
      tick();
      fwd_valid = 1'b0;
      chk("t2_sel_fwd", sel, 1);
      chk("t2_rd_set_fwd", rd_set, 9'h022);
      tick();
      done = 1'b1;
      tick();
      done = 1'b0; #1;
      chk("t2_req_ready", req_ready, 1);
      chk("t2_fwd_ready_c", fwd_ready, 0);
      tick();
      req_valid = 1'b0;
      chk("t2_sel_req", sel, 2);
      chk("t2_rd_set_req", rd_set, 9'h033);
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      chk("t2_starve_cleared", u_dut.starve_cnt, 0);

      // starvation: req wins after exactly 8 fwd grants
      done = 1'b1;
      fwd_valid = 1'b1; fwd_set = 9'h044;
      req_valid = 1'b1; req_set = 9'h055;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk("t3_fwd_ready", fwd_ready, 1);
         chk("t3_req_ready_held", req_ready, 0);
         tick();
         chk("t3_sel_fwd", sel, 1);
         tick();
         tick();
      end
      #1;
      chk("t3_starve_full", u_dut.starve_cnt, 8);
      chk("t3_req_ready", req_ready, 1);
      chk("t3_fwd_ready_blocked", fwd_ready, 0);
      tick();
      chk("t3_sel_req", sel, 2);
      chk("t3_rd_set_req", rd_set, 9'h055);
      chk("t3_starve_zero", u_dut.starve_cnt, 0);
      fwd_valid = 1'b0; req_valid = 1'b0;
      tick();
      tick();

      // stray done in IDLE, done held through READ
      tick();
      chk("t6_idle_rd_mem_en", rd_mem_en, 0);
      chk("t6_idle_lookup_valid", lookup_valid, 0);
      chk("t6_idle_sel", sel, 2);
      req_valid = 1'b1; req_set = 9'h066; #1;
      chk("t6_req_ready", req_ready, 1);
      tick();
      req_valid = 1'b0;
      chk("t6_read_rd_mem_en", rd_mem_en, 1);
      chk("t6_read_lookup_valid", lookup_valid, 0);
      tick();
      chk("t6_lookup_valid", lookup_valid, 1);
      chk("t6_lookup_rd_mem_en", rd_mem_en, 0);
      tick();
      done = 1'b0;
      chk("t6_back_idle_lookup_valid", lookup_valid, 0);
      chk("t6_rd_set_held", rd_set, 9'h066);

      // rst during LOOKUP aborts the transaction
      req_valid = 1'b1; req_set = 9'h100; #1;
      chk("t5_req_ready", req_ready, 1);
      tick();
      tick();
      chk("t5_lookup_valid", lookup_valid, 1);
      rst = 1'b1;
      tick();
      chk("t5_rst_req_ready", req_ready, 0);
      chk("t5_rst_rd_mem_en", rd_mem_en, 0);
      chk("t5_rst_lookup_valid", lookup_valid, 0);
      chk("t5_rst_rd_set", rd_set, 0);
      chk("t5_rst_sel", sel, 0);
      tick();
      chk("t5_rst2_rd_mem_en", rd_mem_en, 0);
      chk("t5_rst2_lookup_valid", lookup_valid, 0);
      rst = 1'b0; #1;
      chk("t5_fresh_req_ready", req_ready, 1);
      tick();
      req_valid = 1'b0;
      chk("t5_fresh_rd_mem_en", rd_mem_en, 1);
      chk("t5_fresh_rd_set", rd_set, 9'h100);
      chk("t5_fresh_sel", sel, 2);
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;

      // full flush on the 3-bit instance, rsp injected mid-walk, req held off
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      done = 1'b1;
      flush_valid = 1'b1; #1;
      chk("t4_flush_ready", f_flush_ready, 1);
      tick();
      flush_valid = 1'b0;
      chk("t4_flush_active", f_flush_active, 1);
      chk("t4_start_rd_mem_en", f_rd_mem_en, 0);
      chk("t4_start_flush_done", f_flush_done, 0);
      req_valid = 1'b1; req_set = 9'h002;
      for (int k = 0; k < 8; k++) begin
         if (k == 4) begin
            rsp_valid = 1'b1; rsp_set = 9'h005; #1;
            chk("t4_rsp_ready", f_rsp_ready, 1);
            tick();
            rsp_valid = 1'b0;
            chk("t4_rsp_sel", f_sel, 0);
            chk("t4_rsp_rd_set", f_rd_set, 5);
            tick();
            tick();
         end
         #1;
         chk("t4_req_held", f_req_ready, 0);
         chk("t4_flush_ready_ignored", f_flush_ready, 0);
         tick();
         chk("t4_step_rd_mem_en", f_rd_mem_en, 1);
         chk("t4_step_sel", f_sel, 3);
         chk("t4_step_rd_set", f_rd_set, k);
         tick();
         chk("t4_step_lookup_valid", f_lookup_valid, 1);
         tick();
      end
      chk("t4_flush_done", f_flush_done, 1);
      chk("t4_flush_inactive", f_flush_active, 0);
      #1;
      chk("t4_req_after_flush", f_req_ready, 1);
      tick();
      req_valid = 1'b0;
      chk("t4_flush_done_pulse", f_flush_done, 0);
      chk("t4_req_sel", f_sel, 2);
      chk("t4_req_rd_set", f_rd_set, 2);
      tick();
      tick();
      done = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
